pipe_hazard_tracker: RTL and testbench
======================================

Name: pipe_hazard_tracker

Overview:
- Producer side of the forwarding interface.
- Carries per-instruction destination tags (rd, regWrite, memRead) through shadow ID/EX, EX/MEM and MEM/WB registers. Drives the ex_mem/mem_wb tag inputs consumed by the forwarding logic.
- Detects hazards forwarding cannot resolve (load-use) and generates stall/flush controls for the OTTER 5-stage pipeline.
- Also freezes the pipeline on data-memory wait and keeps saturating stall/flush counters.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of stall and flush performance counters.

Ports:
- CLK  in  1  pipeline clock.
- RST_N  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_AW  ID source 1.
- id_rs2  in  REG_AW  ID source 2.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  REG_AW  ID destination.
- id_regWrite  in  1  ID writes the register file.
- id_memRead  in  1  ID is a load.
- ex_branch_taken  in  1  branch/jump in EX redirects the PC.
- mem_busy  in  1  data memory not ready; freeze.
- pc_write  out  1  PC enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  zero IF/ID.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- ex_mem_regRd  out  REG_AW  EX/MEM destination tag.
- ex_mem_regWrite  out  1  EX/MEM write flag.
- mem_wb_regRd  out  REG_AW  MEM/WB destination tag.
- mem_wb_regWrite  out  1  MEM/WB write flag.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  branch flushes, saturating.

Behaviour:
- Reset (async, RST_N=0): all shadow registers cleared (rd=0, regWrite=0, memRead=0, valid=0); both counters = 0.
  - Outputs during reset: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, tag outputs 0.
  - Reset mid-stall: stall is dropped immediately (async); the next edge after release samples fresh ID inputs.
- Tag pipeline advances each rising edge when not frozen: IDEX<-ID inputs (or bubble), EXMEM<-IDEX, MEMWB<-EXMEM.
- ex_mem_* outputs drive directly from the EXMEM shadow register; mem_wb_* from MEMWB. No extra latency, so tags align with the datapath pipeline registers.
- regWrite captured into IDEX is id_regWrite & id_valid. rd=0 is kept as-is; consumers ignore x0.
- load_use (internal, combinational) = IDEX.memRead & IDEX.regWrite & IDEX.rd!=0 & (rs1 hit | rs2 hit).
  - rs1 hit = id_valid & id_rs1_used & id_rs1==IDEX.rd; rs2 hit likewise.
- Priority, combinational outputs each cycle:
  1. mem_busy=1: pc_write=0, if_id_write=0, flush=0, bubble=0. All shadow registers and counters hold. Branch and load-use are re-evaluated after the freeze ends.
  2. ex_branch_taken=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. IDEX loads a bubble (valid=0, regWrite=0, memRead=0). flush_cnt+1. Overrides a simultaneous load-use, because the ID instruction is squashed.
  3. load_use=1: pc_write=0, if_id_write=0, id_ex_bubble=1. IDEX loads a bubble. stall_cnt+1.
  4. Otherwise: pc_write=1, if_id_write=1, flush=0, bubble=0.
- Load-use stall lasts exactly 1 cycle: after it, the load sits in EXMEM and forwarding resolves the hazard.
- Back-to-back loads each produce independent 1-cycle stalls.
- Counters saturate at all-ones; no wrap.

Decomposition:
- Shared package: hazard_pkg.
  - tag_t struct {rd, regWrite, memRead, valid}.
  - BUBBLE_TAG constant.
  - Control priority encoding enum {FREEZE, FLUSH, STALL, RUN} for waveform visibility.
- One natural sub-module: sat_counter (CNT_W, en, RST_N), instantiated twice.

Test Plan:
- Load-use: lw x5 in IDEX (memRead=1, rd=5); ID add rs1=5 used=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle. Next cycle ex_mem_regRd=5, ex_mem_regWrite=1, stall_cnt=1.
- x0 and unused source: lw x0 then rs1=0 -> no stall. lw x7 with id_rs2=7 but rs2_used=0 -> no stall.
- Branch + load-use together: ex_branch_taken=1 while load-use is true -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_cnt=1, stall_cnt unchanged.
- Freeze: mem_busy=1 for 3 cycles during load-use -> pc_write=0, tags constant, counters constant. Release -> exactly 1 stall cycle, stall_cnt+1.
- Tag timing: 3 consecutive ALU writes to rd=1,2,3 -> ex_mem_regRd sequence 1,2,3 appears two edges after ID; mem_wb_regRd follows one edge later.
- Reset mid-stall: RST_N low while load_use is active -> tags 0, pc_write=1 immediately. With CNT_W=2, 5 stalls -> stall_cnt=3 (saturated).

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard tracker.
// Tag record carried alongside each instruction through EX, MEM and WB.
package hazard_pkg;

  localparam int TAG_AW = 5;
  localparam int CNT_DW = 16;

  typedef struct packed {
    logic [TAG_AW-1:0] rd;
    logic              regWrite;
    logic              memRead;
    logic              valid;
  } tag_t;

  localparam tag_t BUBBLE_TAG = '{
    rd:       '0,
    regWrite: 1'b0,
    memRead:  1'b0,
    valid:    1'b0
  };

  typedef enum logic [1:0] {
    FREEZE,
    FLUSH,
    STALL,
    RUN
  } ctl_e;

endpackage

// File: rtl/pipe_hazard_tracker_if.sv
// ID-side inputs and stall/flush/tag outputs of the hazard tracker.
// master = pipeline driving ID info, slave = tracker.
interface pipe_hazard_tracker_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_regWrite;
  logic              id_memRead;
  logic              ex_branch_taken;
  logic              mem_busy;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic [REG_AW-1:0] ex_mem_regRd;
  logic              ex_mem_regWrite;
  logic [REG_AW-1:0] mem_wb_regRd;
  logic              mem_wb_regWrite;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output id_rd, id_regWrite, id_memRead,
    output ex_branch_taken, mem_busy,
    input  pc_write, if_id_write,
    input  if_id_flush, id_ex_bubble,
    input  ex_mem_regRd, ex_mem_regWrite,
    input  mem_wb_regRd, mem_wb_regWrite,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  id_rd, id_regWrite, id_memRead,
    input  ex_branch_taken, mem_busy,
    output pc_write, if_id_write,
    output if_id_flush, id_ex_bubble,
    output ex_mem_regRd, ex_mem_regWrite,
    output mem_wb_regRd, mem_wb_regWrite,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Shadow EX/MEM/WB destination tags plus load-use, branch-flush
// and memory-wait control for the 5-stage pipeline.
module pipe_hazard_tracker
  import hazard_pkg::*;
#(
  parameter int REG_AW = TAG_AW,
  parameter int CNT_W  = CNT_DW
) (
  input logic                 CLK,
  input logic                 RST_N,
  pipe_hazard_tracker_if.slave hz
);

  tag_t idex_q, idex_d;
  tag_t exmem_q, memwb_q;
  ctl_e ctl;
  logic rs1_hit, rs2_hit, load_use;
  logic frz, fls, stl;

  assign rs1_hit = hz.id_valid & hz.id_rs1_used
                 & (hz.id_rs1 == idex_q.rd);
  assign rs2_hit = hz.id_valid & hz.id_rs2_used
                 & (hz.id_rs2 == idex_q.rd);

  assign load_use = idex_q.memRead & idex_q.regWrite
                  & (idex_q.rd != '0)
                  & (rs1_hit | rs2_hit);

  // Mutually exclusive terms; reset forces RUN outputs.
  assign frz = RST_N & hz.mem_busy;
  assign fls = RST_N & ~hz.mem_busy & hz.ex_branch_taken;
  assign stl = RST_N & ~hz.mem_busy
             & ~hz.ex_branch_taken & load_use;

  always_comb begin
    ctl = RUN;
    unique case (1'b1)
      frz:     ctl = FREEZE;
      fls:     ctl = FLUSH;
      stl:     ctl = STALL;
      default: ctl = RUN;
    endcase
  end

  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    unique case (ctl)
      FREEZE: begin
        hz.pc_write    = 1'b0;
        hz.if_id_write = 1'b0;
      end
      FLUSH: begin
        hz.if_id_flush  = 1'b1;
        hz.id_ex_bubble = 1'b1;
      end
      STALL: begin
        hz.pc_write     = 1'b0;
        hz.if_id_write  = 1'b0;
        hz.id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    idex_d          = BUBBLE_TAG;
    idex_d.rd       = hz.id_rd;
    idex_d.regWrite = hz.id_regWrite & hz.id_valid;
    idex_d.memRead  = hz.id_memRead;
    idex_d.valid    = hz.id_valid;
    if (ctl == FLUSH || ctl == STALL)
      idex_d = BUBBLE_TAG;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idex_q  <= BUBBLE_TAG;
      exmem_q <= BUBBLE_TAG;
      memwb_q <= BUBBLE_TAG;
    end else if (ctl != FREEZE) begin
      idex_q  <= idex_d;
      exmem_q <= idex_q;
      memwb_q <= exmem_q;
    end
  end

  assign hz.ex_mem_regRd    = exmem_q.rd;
  assign hz.ex_mem_regWrite = exmem_q.regWrite;
  assign hz.mem_wb_regRd    = memwb_q.rd;
  assign hz.mem_wb_regWrite = memwb_q.regWrite;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (ctl == STALL),
    .cnt_o  (hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (ctl == FLUSH),
    .cnt_o  (hz.flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Scoreboard bench: pipeline-level reference model, two DUTs
// (16-bit and 2-bit counters) driven with identical stimulus.
module tb_pipe_hazard_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_tracker_if #(.REG_AW(5), .CNT_W(16)) hm();
  pipe_hazard_tracker_if #(.REG_AW(5), .CNT_W(2))  hs();

  pipe_hazard_tracker #(.REG_AW(5), .CNT_W(16)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .hz    (hm.slave)
  );

  pipe_hazard_tracker #(.REG_AW(5), .CNT_W(2)) dut_s (
    .CLK   (clk),
    .RST_N (rst_n),
    .hz    (hs.slave)
  );

  assign hs.id_valid        = hm.id_valid;
  assign hs.id_rs1          = hm.id_rs1;
  assign hs.id_rs2          = hm.id_rs2;
  assign hs.id_rs1_used     = hm.id_rs1_used;
  assign hs.id_rs2_used     = hm.id_rs2_used;
  assign hs.id_rd           = hm.id_rd;
  assign hs.id_regWrite     = hm.id_regWrite;
  assign hs.id_memRead      = hm.id_memRead;
  assign hs.ex_branch_taken = hm.ex_branch_taken;
  assign hs.mem_busy        = hm.mem_busy;

  typedef struct {
    bit v; int rs1; int rs2; bit u1; bit u2;
    int rd; bit wr; bit ld; bit br; bit busy; bit rst;
  } stim_t;

  typedef struct {
    bit v; int rd; bit wr; bit ld;
  } inst_t;

  typedef struct {
    string nm;
    bit [3:0] ctl;
    int tags;
    int sc; int fc; int ssc; int sfc;
  } exp_t;

  exp_t  sb[$];
  inst_t pipe[$];
  int    n_stall, n_flush;
  int    checks = 0;
  int    passed = 0;

  function automatic stim_t mk(bit v, int rs1, int rs2,
                               bit u1, bit u2, int rd, bit wr,
                               bit ld, bit br, bit busy, bit rst);
    stim_t s;
    s.v = v; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
    s.rd = rd; s.wr = wr; s.ld = ld; s.br = br;
    s.busy = busy; s.rst = rst;
    return s;
  endfunction

  function automatic stim_t lw(int rd);
    return mk(1, 0, 0, 0, 0, rd, 1, 1, 0, 0, 1);
  endfunction

  function automatic stim_t use1(int rs, bit br, bit busy);
    return mk(1, rs, 0, 1, 0, 9, 1, 0, br, busy, 1);
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  function automatic int pack_tags(int er, bit ew, int mr, bit mw);
    return (er << 7) | (int'(ew) << 6) | (mr << 1) | int'(mw);
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Apply one cycle of ID-side stimulus and predict the response.
  task automatic step(input stim_t s, input string nm);
    exp_t  e;
    inst_t nop, ex;
    bit    hz;
    @(negedge clk);
    rst_n                = s.rst;
    hm.id_valid          = s.v;
    hm.id_rs1            = 5'(s.rs1);
    hm.id_rs2            = 5'(s.rs2);
    hm.id_rs1_used       = s.u1;
    hm.id_rs2_used       = s.u2;
    hm.id_rd             = 5'(s.rd);
    hm.id_regWrite       = s.wr;
    hm.id_memRead        = s.ld;
    hm.ex_branch_taken   = s.br;
    hm.mem_busy          = s.busy;
    nop = '{v: 0, rd: 0, wr: 0, ld: 0};
    if (!s.rst) begin
      pipe = {nop, nop, nop};
      n_stall = 0;
      n_flush = 0;
    end
    ex = pipe[0];
    hz = s.v && ex.ld && ex.wr && ex.rd != 0 &&
         ((s.u1 && s.rs1 == ex.rd) || (s.u2 && s.rs2 == ex.rd));
    e.nm = nm;
    if (!s.rst)      e.ctl = 4'b1100;
    else if (s.busy) e.ctl = 4'b0000;
    else if (s.br)   e.ctl = 4'b1111;
    else if (hz)     e.ctl = 4'b0001;
    else             e.ctl = 4'b1100;
    e.tags = pack_tags(pipe[1].rd, pipe[1].wr,
                       pipe[2].rd, pipe[2].wr);
    e.sc  = sat(n_stall, 65535);
    e.fc  = sat(n_flush, 65535);
    e.ssc = sat(n_stall, 3);
    e.sfc = sat(n_flush, 3);
    sb.push_back(e);
    if (s.rst && !s.busy) begin
      if (s.br)    n_flush++;
      else if (hz) n_stall++;
      void'(pipe.pop_back());
      if (s.br || hz) pipe.push_front(nop);
      else pipe.push_front('{v: s.v, rd: s.rd,
                             wr: s.wr && s.v, ld: s.ld});
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.nm, " ctl"}, int'({hm.pc_write, hm.if_id_write,
                                  hm.if_id_flush, hm.id_ex_bubble}),
            int'(e.ctl));
        chk({e.nm, " ctl_s"}, int'({hs.pc_write, hs.if_id_write,
                                    hs.if_id_flush, hs.id_ex_bubble}),
            int'(e.ctl));
        chk({e.nm, " tags"},
            pack_tags(int'(hm.ex_mem_regRd), hm.ex_mem_regWrite,
                      int'(hm.mem_wb_regRd), hm.mem_wb_regWrite),
            e.tags);
        chk({e.nm, " stall_cnt"}, int'(hm.stall_cnt), e.sc);
        chk({e.nm, " flush_cnt"}, int'(hm.flush_cnt), e.fc);
        chk({e.nm, " stall_cnt_w2"}, int'(hs.stall_cnt), e.ssc);
        chk({e.nm, " flush_cnt_w2"}, int'(hs.flush_cnt), e.sfc);
      end
    end
  end

  initial begin
    stim_t r;
    pipe = {};
    for (int i = 0; i < 3; i++) pipe.push_back('{v: 0, rd: 0, wr: 0, ld: 0});
    n_stall = 0;
    n_flush = 0;
    r = idle();
    r.rst = 0;
    step(r, "reset0");
    step(r, "reset1");

    step(lw(5), "lu_load");
    step(use1(5, 0, 0), "lu_stall");
    step(use1(5, 0, 0), "lu_after");
    step(idle(), "lu_drain");

    step(lw(0), "x0_load");
    step(use1(0, 0, 0), "x0_use");
    step(lw(7), "unused_load");
    step(mk(1, 0, 7, 1, 0, 9, 1, 0, 0, 0, 1), "unused_rs2");
    step(idle(), "unused_drain");

    step(lw(5), "brlu_load");
    step(use1(5, 1, 0), "brlu_both");
    step(idle(), "brlu_drain");

    step(lw(5), "frz_load");
    for (int i = 0; i < 3; i++) step(use1(5, 0, 1), "frz_busy");
    step(use1(5, 0, 0), "frz_stall");
    step(use1(5, 0, 0), "frz_after");

    for (int i = 1; i <= 3; i++)
      step(mk(1, 0, 0, 0, 0, i, 1, 0, 0, 0, 1), "alu_seq");
    for (int i = 0; i < 3; i++) step(idle(), "alu_drain");

    step(lw(5), "rst_load");
    r = use1(5, 0, 0);
    r.rst = 0;
    step(r, "rst_mid_stall");
    step(use1(5, 0, 0), "rst_release");

    for (int k = 1; k <= 5; k++) begin
      step(lw(k), "sat_load");
      step(use1(k, 0, 0), "sat_stall");
      step(use1(k, 0, 0), "sat_after");
    end

    for (int i = 0; i < 400; i++) begin
      r.v    = ($urandom % 4) != 0;
      r.rs1  = $urandom % 8;
      r.rs2  = $urandom % 8;
      r.u1   = $urandom % 2;
      r.u2   = $urandom % 2;
      r.rd   = $urandom % 8;
      r.wr   = ($urandom % 4) != 0;
      r.ld   = $urandom % 2;
      r.br   = ($urandom % 10) == 0;
      r.busy = ($urandom % 7) == 0;
      r.rst  = ($urandom % 60) != 0;
      step(r, "rand");
    end
    step(idle(), "final");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #5;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
